vga_fb_arbiter: RTL and testbench

- Shares one single-port, synchronous-read frame-buffer RAM between two requesters: the VGA display fetch path and a pixel writer (camera/CPU).
- The display fetch is driven by the pixel timing outputs (pixel strobe, DE, x/y) and has absolute priority.
- Writes use a valid/ready handshake and are granted in every memory slot the display does not use.
- Sits between the VGA timing generator, the writer, and the frame-buffer RAM; delivers one registered pixel word per pixel period.

---
 rtl/vga_fb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares one single-port, synchronous-read frame-buffer RAM
//               between the VGA display fetch path and a pixel writer.
//               Display fetch has absolute priority. The writer is granted
//               every RAM slot that the display does not use.
//               Optional build macro VGA_ARB_STATS_EN enables the write-stall
//               and underrun counters. When the macro is undefined, both
//               counter ports are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int FB_W        = 320,
  parameter int SCALE_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic              de,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              clr_status,
  output logic [15:0]       wr_stall_cnt,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRD  = 2'd1,
    ST_DCAP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_pix_data;
  logic                r_pix_valid;
  logic                r_underrun;
  logic                r_blank_s1;
  logic                r_blank_s2;

  logic [9:0]          w_xs;
  logic [9:0]          w_ys;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_fetch_start;
  logic                w_blank_arm;
  logic                w_underrun_evt;
  logic                w_wr_ready;
  logic                w_mem_en;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;

  // Down-scaled pixel coordinates mapped to a linear frame-buffer word address.
  assign w_xs         = x_pixel >> SCALE_SHIFT;
  assign w_ys         = y_pixel >> SCALE_SHIFT;
  assign w_fetch_addr = ADDR_W'(32'(w_ys) * 32'(FB_W) + 32'(w_xs));

  // State register. An asynchronous reset drops any read that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic plus the RAM port mux. The display read owns DRD.
  // Every other cycle is offered to the writer.
  always_comb begin
    w_state_next   = r_state;
    w_fetch_start  = 1'b0;
    w_blank_arm    = 1'b0;
    w_underrun_evt = 1'b0;
    w_wr_ready     = 1'b1;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = wr_addr;
    case (r_state)
      ST_IDLE: begin
        if (pix_tick) begin
          if (de) begin
            w_fetch_start = 1'b1;
            w_state_next  = ST_DRD;
          end else begin
            w_blank_arm   = 1'b1;
          end
        end
      end
      ST_DRD: begin
        w_wr_ready   = 1'b0;
        w_mem_en     = 1'b1;
        w_mem_addr   = r_addr;
        w_state_next = ST_DCAP;
        if (pix_tick) w_underrun_evt = 1'b1;
      end
      ST_DCAP: begin
        w_state_next = ST_IDLE;
        if (pix_tick) w_underrun_evt = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (wr_valid && w_wr_ready) begin
      w_mem_en = 1'b1;
      w_mem_we = 1'b1;
    end
  end

  assign wr_ready  = w_wr_ready;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = wr_data;

  // Latch the fetch address on an accepted display tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_addr <= '0;
    else if (w_fetch_start) r_addr <= w_fetch_addr;
  end

  // Two-stage delay so that blank pixels appear with the same latency as fetched pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blank_s1 <= 1'b0;
      r_blank_s2 <= 1'b0;
    end else begin
      r_blank_s1 <= w_blank_arm;
      r_blank_s2 <= r_blank_s1;
    end
  end

  // Pixel output register. It captures read data in DCAP and zero for blank slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
    end else if (r_state == ST_DCAP) begin
      r_pix_data  <= mem_rdata;
      r_pix_valid <= 1'b1;
    end else if (r_blank_s2) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b1;
    end else begin
      r_pix_valid <= 1'b0;
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;

  // Sticky overrun flag. A new event takes precedence over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_underrun <= 1'b0;
    else if (w_underrun_evt) r_underrun <= 1'b1;
    else if (clr_status)     r_underrun <= 1'b0;
  end

  assign underrun = r_underrun;

`ifdef VGA_ARB_STATS_EN
  logic [15:0] r_wr_stall_cnt;
  logic [7:0]  r_underrun_cnt;

  // Saturating count of cycles in which the writer waited on a display read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_wr_stall_cnt <= '0;
    else if (clr_status)                             r_wr_stall_cnt <= '0;
    else if (wr_valid && !w_wr_ready && (r_wr_stall_cnt != 16'hFFFF))
                                                     r_wr_stall_cnt <= r_wr_stall_cnt + 16'd1;
  end

  // Saturating count of overrun events. An event in a clear cycle leaves the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_underrun_cnt <= '0;
    else if (w_underrun_evt && clr_status)           r_underrun_cnt <= 8'd1;
    else if (clr_status)                             r_underrun_cnt <= '0;
    else if (w_underrun_evt && (r_underrun_cnt != 8'hFF))
                                                     r_underrun_cnt <= r_underrun_cnt + 8'd1;
  end

  assign wr_stall_cnt = r_wr_stall_cnt;
  assign underrun_cnt = r_underrun_cnt;
`else
  assign wr_stall_cnt = 16'd0;
  assign underrun_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Self-checking bench for vga_fb_arbiter. It uses a table of
//               display ticks, a pixel scoreboard queue, and hand-written
//               sequences for reset, contention, blanking and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

`ifdef VGA_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, reset, pix_tick, de, wr_valid, wr_ready, clr_status;
  logic [9:0]  x_pixel, y_pixel;
  logic [16:0] wr_addr, mem_addr;
  logic [15:0] wr_data, mem_wdata, mem_rdata, pix_data, wr_stall_cnt;
  logic        mem_en, mem_we, pix_valid, underrun;
  logic [7:0]  underrun_cnt;
  logic [15:0] rd_word;

  int checks = 0;
  int failures = 0;
  int pv_count = 0;
  int pushes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;

  typedef struct {
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rdata;
    logic [16:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .clr_status(clr_status),
    .wr_stall_cnt(wr_stall_cnt), .underrun_cnt(underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM model: read data appears on the clock after the read.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= rd_word;
  end

  // Scoreboard: every pixel pulse must match the next expected word.
  always @(negedge clk) begin
    if (!reset && pix_valid) begin
      pv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pix_unexpected actual=%h required=<no pixel expected>", pix_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (pix_data !== exp_e) begin
          failures++;
          $display("FAIL pix_data actual=%h required=%h", pix_data, exp_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    cyc(); clr_status = 1'b1;
    cyc(); clr_status = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    exp_q.push_back(d);
    pushes++;
  endtask

  int writes, stalls, rd_hits;

  initial begin
    vecs[0] = '{1'b1, 10'd5,   10'd3,   16'hABCD, 17'd322,   16'hABCD};
    vecs[1] = '{1'b1, 10'd639, 10'd479, 16'h1234, 17'd76799, 16'h1234};
    vecs[2] = '{1'b1, 10'd0,   10'd0,   16'hFFFF, 17'd0,     16'hFFFF};
    vecs[3] = '{1'b0, 10'd8,   10'd8,   16'h9999, 17'd0,     16'h0000};
    vecs[4] = '{1'b1, 10'd100, 10'd200, 16'h5A5A, 17'd32050, 16'h5A5A};
    vecs[5] = '{1'b1, 10'd1,   10'd1,   16'h0001, 17'd0,     16'h0001};

    reset = 1'b1; pix_tick = 0; de = 0; x_pixel = 0; y_pixel = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0; clr_status = 0; rd_word = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_stall_cnt", wr_stall_cnt, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);
    cyc(); reset = 1'b0;

    // Table-driven display ticks, one pixel period of 4 clocks each.
    for (int i = 0; i < 6; i++) begin
      cyc();
      pix_tick = 1; de = vecs[i].de; x_pixel = vecs[i].x; y_pixel = vecs[i].y;
      rd_word = vecs[i].rdata;
      push(vecs[i].exp_data);
      #1;
      chk($sformatf("v%0d_tick_ready", i), wr_ready, 1);
      cyc(); pix_tick = 0; #1;
      if (vecs[i].de) begin
        chk($sformatf("v%0d_mem_en", i), mem_en, 1);
        chk($sformatf("v%0d_mem_we", i), mem_we, 0);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_drd_ready", i), wr_ready, 0);
      end else begin
        chk($sformatf("v%0d_blank_mem_en", i), mem_en, 0);
        chk($sformatf("v%0d_blank_ready", i), wr_ready, 1);
      end
      cyc(); #1;
      chk($sformatf("v%0d_valid_early", i), pix_valid, 0);
      cyc(); #1;
      chk($sformatf("v%0d_valid", i), pix_valid, 1);
    end

    // Reset asserted while the read is being issued.
    cyc();
    pix_tick = 1; de = 1; x_pixel = 10'd5; y_pixel = 10'd3; rd_word = 16'hCAFE;
    cyc(); pix_tick = 0; #1;
    chk("rstmid_mem_en_before", mem_en, 1);
    reset = 1'b1; #1;
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_pix_data", pix_data, 0);
    cyc(); cyc(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("rstmid_no_valid", pix_valid, 0);
    end
    chk("rstmid_pix_data_after", pix_data, 0);
    chk("rstmid_idle_ready", wr_ready, 1);

    // Contention: a continuous writer gets 3 of every 4 slots.
    pulse_clr();
    wr_valid = 1; wr_addr = 17'h00010; wr_data = 16'h7777;
    writes = 0; stalls = 0; rd_hits = 0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        cyc();
        if (k == 0) begin
          pix_tick = 1; de = 1; x_pixel = 10'(2 * j); y_pixel = 0;
          rd_word = 16'(16'h1000 + j);
          push(16'(16'h1000 + j));
        end else begin
          pix_tick = 0;
        end
        #1;
        if (mem_en && mem_we) writes++;
        if (!wr_ready) stalls++;
        if (mem_en && !mem_we && mem_addr == 17'(j)) rd_hits++;
        if (k == 1) chk("cont_ready_drd", wr_ready, 0);
        if (k == 2) chk("cont_ready_dcap", wr_ready, 1);
      end
    end
    chk("cont_writes", writes, 12);
    chk("cont_stalls", stalls, 4);
    chk("cont_reads", rd_hits, 4);
    chk("cont_stall_cnt", wr_stall_cnt, STATS ? 4 : 0);

    // Blanking: the writer owns all 4 slots.
    writes = 0; rd_hits = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        pix_tick = 1; de = 0; push(16'h0000);
      end else begin
        pix_tick = 0;
      end
      #1;
      if (mem_en && mem_we) writes++;
      if (mem_en && !mem_we) rd_hits++;
    end
    chk("blank_writes", writes, 4);
    chk("blank_reads", rd_hits, 0);
    chk("blank_valid", pix_valid, 1);
    wr_valid = 0;

    // Overrun: a second tick 2 clocks after the first is dropped.
    pulse_clr();
    cyc();
    pix_tick = 1; de = 1; x_pixel = 10'd5; y_pixel = 10'd3; rd_word = 16'hBEEF;
    push(16'hBEEF);
    cyc(); pix_tick = 0;
    cyc(); pix_tick = 1; x_pixel = 10'd7;
    cyc(); pix_tick = 0; #1;
    chk("ovr_underrun", underrun, 1);
    cyc(); #1;
    chk("ovr_valid_once", pix_valid, 0);
    chk("ovr_sticky", underrun, 1);
    chk("ovr_cnt", underrun_cnt, STATS ? 1 : 0);
    pulse_clr();
    #1;
    chk("ovr_clr_underrun", underrun, 0);
    chk("ovr_clr_cnt", underrun_cnt, 0);

    repeat (6) cyc();
    chk("sb_queue_empty", exp_q.size(), 0);
    chk("sb_pulse_count", pv_count, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
